// File: rtl/mbc_pkg.sv
// mbc_pkg: shared constants, types and helpers for the mbc_banker slice.
//   - register-map selectors (MODE_MBC1 / MODE_MBC5)
//   - RAM enable key and CPU-side region decode constants
//   - internal bank/address widths and the RB_W helper
// Optional feature macro used by this slice: MBC_RAM_GATE_EN.
package mbc_pkg;

  localparam int MODE_MBC1 = 1;
  localparam int MODE_MBC5 = 5;

  localparam logic [3:0] RAM_EN_KEY = 4'hA;

  // CPU address regions
  localparam logic [15:0] ROM0_LIMIT = 16'h3FFF;
  localparam logic [15:0] ROMX_LIMIT = 16'h7FFF;
  localparam logic [15:0] CRAM_BASE  = 16'hA000;
  localparam logic [15:0] CRAM_LIMIT = 16'hBFFF;

  // Internal widths: widest bank (MBC5, 9 bits), RAM bank field, widest address
  localparam int BANK_W = 9;
  localparam int RAMB_W = 4;
  localparam int FULL_W = 23;

  typedef enum logic [1:0] {
    RGN_ROM0  = 2'd0,
    RGN_ROMX  = 2'd1,
    RGN_CRAM  = 2'd2,
    RGN_OTHER = 2'd3
  } region_t;

  // ROM bank field width for a given physical address width
  function automatic int rb_width(input int oadr_w);
    return oadr_w - 14;
  endfunction

  // True when the low nibble written to 0000-1FFF unlocks cartridge RAM
  function automatic logic ram_key_match(input logic [3:0] d);
    return (d == RAM_EN_KEY);
  endfunction

  function automatic region_t decode_region(input logic [15:0] adr);
    region_t r;
    if (adr <= ROM0_LIMIT) begin
      r = RGN_ROM0;
    end else if (adr <= ROMX_LIMIT) begin
      r = RGN_ROMX;
    end else if ((adr >= CRAM_BASE) && (adr <= CRAM_LIMIT)) begin
      r = RGN_CRAM;
    end else begin
      r = RGN_OTHER;
    end
    return r;
  endfunction

endpackage

// File: rtl/mbc_bank_regs.sv
// mbc_bank_regs: write-edge detector and bank registers for one MBC register map.
// Parameter MODE selects the map (1 = MBC1, 5 = MBC5).
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_write             CPU write strobe (level)
//   i_data              CPU write data
//   i_iadr_hi           CPU address bits [15:12]
//   o_bank0             bank used for CPU 0000-3FFF
//   o_bankx             bank used for CPU 4000-7FFF
//   o_ram_bank          RAM bank (before reduction to RAM_BANKS)
//   o_ram_en            RAM enable (constant 1 when MBC_RAM_GATE_EN is undefined)
// Macro MBC_RAM_GATE_EN: when defined, keeps the ram_en register written via 0000-1FFF.
module mbc_bank_regs
  import mbc_pkg::*;
#(
  parameter int MODE = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_write,
  input  logic [7:0]        i_data,
  input  logic [3:0]        i_iadr_hi,
  output logic [BANK_W-1:0] o_bank0,
  output logic [BANK_W-1:0] o_bankx,
  output logic [RAMB_W-1:0] o_ram_bank,
  output logic              o_ram_en
);

  logic              r_write_q;
  logic [4:0]        r_bank_lo;
  logic [1:0]        r_bank_hi;
  logic              r_mode_sel;
  logic [8:0]        r_bank5;
  logic [3:0]        r_ram_bank5;
`ifdef MBC_RAM_GATE_EN
  logic              r_ram_en;
`endif
  logic              w_wr_edge;

  // Only the rising edge of a (possibly long) write into 0000-7FFF updates state
  assign w_wr_edge = i_write && !r_write_q && !i_iadr_hi[3];

  // Write-edge history and register-map decode
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_write_q   <= 1'b0;
      r_bank_lo   <= 5'd1;
      r_bank_hi   <= 2'd0;
      r_mode_sel  <= 1'b0;
      r_bank5     <= 9'd1;
      r_ram_bank5 <= 4'd0;
`ifdef MBC_RAM_GATE_EN
      r_ram_en    <= 1'b0;
`endif
    end else begin
      r_write_q <= i_write;
      if (w_wr_edge) begin
        if (MODE == MODE_MBC1) begin
          case (i_iadr_hi[2:1])
            2'b00: begin
`ifdef MBC_RAM_GATE_EN
              r_ram_en <= ram_key_match(i_data[3:0]);
`endif
            end
            // bank_lo of 0 would alias the fixed bank, so it becomes 1
            2'b01:   r_bank_lo  <= (i_data[4:0] == 5'd0) ? 5'd1 : i_data[4:0];
            2'b10:   r_bank_hi  <= i_data[1:0];
            2'b11:   r_mode_sel <= i_data[0];
            default: r_mode_sel <= r_mode_sel;
          endcase
        end else begin
          case (i_iadr_hi[2:0])
            3'b000, 3'b001: begin
`ifdef MBC_RAM_GATE_EN
              r_ram_en <= ram_key_match(i_data[3:0]);
`endif
            end
            3'b010:         r_bank5[7:0] <= i_data;
            3'b011:         r_bank5[8]   <= i_data[0];
            3'b100, 3'b101: r_ram_bank5  <= i_data[3:0];
            default:        r_ram_bank5  <= r_ram_bank5;
          endcase
        end
      end
    end
  end

  // Effective banks for the active register map
  always_comb begin
    o_bank0    = 9'd0;
    o_bankx    = 9'd0;
    o_ram_bank = 4'd0;
    if (MODE == MODE_MBC1) begin
      o_bank0    = r_mode_sel ? {2'b00, r_bank_hi, 5'b00000} : 9'd0;
      o_bankx    = {2'b00, r_bank_hi, r_bank_lo};
      o_ram_bank = r_mode_sel ? {2'b00, r_bank_hi} : 4'd0;
    end else begin
      o_bank0    = 9'd0;
      o_bankx    = r_bank5;
      o_ram_bank = r_ram_bank5;
    end
  end

`ifdef MBC_RAM_GATE_EN
  assign o_ram_en = r_ram_en;
`else
  assign o_ram_en = 1'b1;
`endif

endmodule

// File: rtl/mbc_banker.sv
// mbc_banker: cartridge memory-bank controller emulation (MBC1 / MBC5 maps).
// Parameters: MODE (1 or 5), OADR_W (15..23), RAM_BANKS (power of two, 1..16).
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   read, write  CPU strobes (level)
//   data         CPU write data
//   iadr         CPU address
//   oadr         physical ROM/RAM address (combinational, 0 during reset)
//   sel_rom      cartridge ROM select
//   sel_ram      cartridge RAM select
//   rom_bank     effective 4000-7FFF bank after truncation to RB_W
// Macro MBC_RAM_GATE_EN: when defined, sel_ram is gated by the ram_en register.
module mbc_banker
  import mbc_pkg::*;
#(
  parameter int  MODE      = 1,
  parameter int  OADR_W    = 21,
  parameter int  RAM_BANKS = 4,
  localparam int RB_W      = rb_width(OADR_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              read,
  input  logic              write,
  input  logic [7:0]        data,
  input  logic [15:0]       iadr,
  output logic [OADR_W-1:0] oadr,
  output logic              sel_rom,
  output logic              sel_ram,
  output logic [RB_W-1:0]   rom_bank
);

  if ((MODE != MODE_MBC1) && (MODE != MODE_MBC5)) begin : g_bad_mode
    $error("mbc_banker: MODE must be 1 or 5");
  end
  if ((OADR_W < 15) || (OADR_W > 23)) begin : g_bad_oadr_w
    $error("mbc_banker: OADR_W must be in 15..23");
  end
  if ((RAM_BANKS < 1) || (RAM_BANKS > 16) || ((RAM_BANKS & (RAM_BANKS - 1)) != 0)) begin : g_bad_ram_banks
    $error("mbc_banker: RAM_BANKS must be a power of two in 1..16");
  end

  localparam logic [RAMB_W-1:0] RAM_MASK = RAMB_W'(RAM_BANKS - 1);

  logic [BANK_W-1:0] w_bank0;
  logic [BANK_W-1:0] w_bankx;
  logic [RAMB_W-1:0] w_ram_bank;
  logic              w_ram_en;
  region_t           w_region;
  logic [FULL_W-1:0] w_full;
  logic              w_access;
  logic              w_unused;

  mbc_bank_regs #(
    .MODE (MODE)
  ) u_regs (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_write    (write),
    .i_data     (data),
    .i_iadr_hi  (iadr[15:12]),
    .o_bank0    (w_bank0),
    .o_bankx    (w_bankx),
    .o_ram_bank (w_ram_bank),
    .o_ram_en   (w_ram_en)
  );

  assign w_region = decode_region(iadr);
  assign w_access = read || write;

  // Widest-case physical address; truncation to OADR_W makes high bank bits wrap
  always_comb begin
    w_full = '0;
    case (w_region)
      RGN_ROM0: w_full = {w_bank0, iadr[13:0]};
      RGN_ROMX: w_full = {w_bankx, iadr[13:0]};
      RGN_CRAM: w_full = {6'd0, w_ram_bank & RAM_MASK, iadr[12:0]};
      default:  w_full = {7'd0, iadr};
    endcase
  end

  assign oadr     = reset ? '0 : w_full[OADR_W-1:0];
  assign rom_bank = w_bankx[RB_W-1:0];
  assign sel_rom  = !reset && w_access && !iadr[15];
  assign sel_ram  = !reset && w_access && (w_region == RGN_CRAM) && w_ram_en;

  // Bits above OADR_W / RB_W are dropped on purpose
  assign w_unused = ^{w_full, w_bankx};

endmodule
